aes_iter_ctrl: RTL and testbench

//   Iterative AES-128 encryption engine with a valid/ready block interface.

---
 rtl/aes_iter_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_aes_iter_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_iter_ctrl
// Brief   : Iterative AES-128 encryptor, one round per clock, valid/ready I/O.
// Revision: 1.0
// ============================================================================
module aes_iter_ctrl #(
    parameter int NR         = 10,
    parameter int IDLE_CLEAR = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_iter_ctrl: only NR=10 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (b^254 by square-and-multiply) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(r)) v = xtime(v);
        end
        return v;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_e       st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;
    logic [3:0]   rnd_q, rnd_d;

    logic [127:0] sb_sr;
    logic [127:0] rkey;
    logic [127:0] round_out;
    logic [127:0] final_out;

    // Both round flavours share SubBytes/ShiftRows and the key step; only MixColumns differs
    assign sb_sr     = sub_shift(state_q);
    assign rkey      = next_key(key_q, rcon(rnd_q));
    assign round_out = mix(sb_sr) ^ rkey;
    assign final_out = sb_sr ^ rkey;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            state_q <= '0;
            key_q   <= '0;
            out_q   <= '0;
            rnd_q   <= '0;
        end else begin
            st_q    <= st_d;
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        key_d   = key_q;
        out_d   = out_q;
        rnd_d   = rnd_q;
        case (st_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data ^ in_key;
                    key_d   = in_key;
                    rnd_d   = 4'd0;
                    st_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                if (rnd_q == 4'(NR - 1)) begin
                    out_d = final_out;
                    st_d  = S_DONE;
                end else begin
                    state_d = round_out;
                    key_d   = rkey;
                    rnd_d   = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    st_d = S_IDLE;
                    if (IDLE_CLEAR != 0) begin
                        state_d = '0;
                        key_d   = '0;
                    end
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    assign in_ready  = (st_q == S_IDLE);
    assign out_valid = (st_q == S_DONE);
    assign busy      = (st_q != S_IDLE);
    assign out_data  = out_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_iter_ctrl
// Brief   : Self-checking bench for aes_iter_ctrl against a table-driven AES model.
// Revision: 1.0
// ============================================================================
module tb_aes_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    localparam logic [127:0] C_K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_C2  = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_iter_ctrl #(.NR(10), .IDLE_CLEAR(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_key   (in_key),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model: exp/log tables over generator 3 ----------------
    logic [7:0] exp_t [256];
    int         log_t [256];
    logic [7:0] sbox_t[256];

    task automatic build_tables();
        logic [7:0] p, inv, s, c;
        p = 8'h01;
        c = 8'h63;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = p;
            log_t[p] = i;
            p = p ^ ({p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00));
        end
        sbox_t[0] = 8'h63;
        for (int x = 1; x < 256; x++) begin
            inv = exp_t[(255 - log_t[x]) % 255];
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [7:0] gf(input logic [7:0] a, input logic [7:0] b);
        if (a == 0 || b == 0) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w[44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   st[16];
        logic [7:0]   tmp[16];
        logic [7:0]   a[4];
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 16; j++) st[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r+4*c] = sbox_t[st[r+4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = tmp[r+4*c];
                for (int r = 0; r < 4; r++) begin
                    if (rd < 10)
                        st[r+4*c] = gf(8'h02, a[r]) ^ gf(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                    else
                        st[r+4*c] = a[r];
                    st[r+4*c] = st[r+4*c] ^ w[4*rd+c][31-8*r -: 8];
                end
            end
        end
        for (int j = 0; j < 16; j++) res[127-8*j -: 8] = st[j];
        return res;
    endfunction

    // ---------------- drive helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Present one block, return first valid ciphertext and cycles from accept edge to valid
    task automatic run_one(input logic [127:0] pt, input logic [127:0] key, input int hold,
                           output logic [127:0] got, output int lat, output bit to);
        int n;
        to = 1'b0;
        in_data = pt; in_key = key; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
        if (in_ready !== 1'b1) to = 1'b1;
        tick();
        in_valid = 1'b0; in_data = rand128(); in_key = rand128();
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        if (out_valid !== 1'b1) to = 1'b1;
        lat = n - 1;
        got = out_data;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_key = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out_data=%h, required 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_kat(input string nm, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] ct);
        logic [127:0] got;
        int lat;
        bit to;
        run_one(pt, key, 0, got, lat, to);
        vectors++;
        if (to !== 1'b0) begin
            miscompares++; $display("FAIL %s_timeout: handshake did not complete", nm);
        end
        vectors++;
        if (got !== ct) begin
            miscompares++; $display("FAIL %s_data: got %h required %h", nm, got, ct);
        end
        vectors++;
        if (lat != 10) begin
            miscompares++; $display("FAIL %s_latency: got %0d required 10", nm, lat);
        end
        vectors++;
        if (aes_ref(pt, key) !== ct) begin
            miscompares++; $display("FAIL %s_model: model %h required %h", nm, aes_ref(pt, key), ct);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, key, d0;
        int n;
        bit ok;
        pt = rand128(); key = rand128();
        in_data = pt; in_key = key; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        d0 = out_data;
        ok = (out_valid === 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== d0 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL bp_hold: outputs moved under backpressure, last out_valid=%b in_ready=%b data=%h first=%h",
                                    out_valid, in_ready, out_data, d0);
        end
        vectors++;
        if (d0 !== aes_ref(pt, key)) begin
            miscompares++; $display("FAIL bp_data: got %h required %h", d0, aes_ref(pt, key));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_busy_ignore();
        logic [127:0] pt2, key2, got;
        int n;
        bit rdy_low;
        pt2 = rand128(); key2 = rand128();
        in_data = C_P1; in_key = C_K1; in_valid = 1'b1;
        tick();
        in_data = pt2; in_key = key2;
        rdy_low = 1'b1;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (in_ready !== 1'b0) rdy_low = 1'b0;
            tick(); n++;
        end
        got = out_data;
        vectors++;
        if (got !== C_C1 || !rdy_low) begin
            miscompares++; $display("FAIL busy_first: got %h required %h, in_ready stayed low=%b", got, C_C1, rdy_low);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL busy_handshake_only: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL busy_accept_next: busy=%b required 1", busy);
        end
        n = 1;
        while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
        vectors++;
        if (out_data !== aes_ref(pt2, key2) || n - 1 != 10) begin
            miscompares++; $display("FAIL busy_second: got %h lat %0d required %h lat 10", out_data, n - 1, aes_ref(pt2, key2));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int lat;
        bit to, rose;
        in_data = C_P1; in_key = C_K1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            miscompares++; $display("FAIL rstmid_state: in_ready=%b out_valid=%b busy=%b out_data=%h required 1 0 0 0",
                                    in_ready, out_valid, busy, out_data);
        end
        rose = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid !== 1'b0) rose = 1'b1;
        end
        vectors++;
        if (rose) begin
            miscompares++; $display("FAIL rstmid_no_output: out_valid rose=1 required 0");
        end
        run_one(C_P1, C_K1, 0, got, lat, to);
        vectors++;
        if (got !== C_C1 || to) begin
            miscompares++; $display("FAIL rstmid_after: got %h required %h", got, C_C1);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, key, got, exp;
        int lat;
        bit to;
        for (int i = 0; i < 8; i++) begin
            pt = rand128(); key = rand128();
            exp = aes_ref(pt, key);
            run_one(pt, key, int'($urandom_range(0, 3)), got, lat, to);
            vectors++;
            if (got !== exp || lat != 10 || to) begin
                miscompares++; $display("FAIL random_%0d: got %h lat %0d required %h lat 10", i, got, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_q[$];
        logic [127:0] e;
        int acc[4];
        int nacc, nres;
        bit pend;
        nacc = 0; nres = 0; pend = 1'b0;
        in_data = rand128(); in_key = rand128();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int it = 0; it < 80 && nres < 4; it++) begin
            if (pend) begin
                pend = 1'b0;
                if (nacc < 4) begin in_data = rand128(); in_key = rand128(); end
                else in_valid = 1'b0;
            end
            if (out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                vectors++;
                if (out_data !== e) begin
                    miscompares++; $display("FAIL b2b_data_%0d: got %h required %h", nres, out_data, e);
                end
                nres++;
            end
            if (in_ready === 1'b1 && in_valid && nacc < 4) begin
                acc[nacc] = cyc;
                exp_q.push_back(aes_ref(in_data, in_key));
                nacc++;
                pend = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        vectors++;
        if (nacc != 4 || nres != 4) begin
            miscompares++; $display("FAIL b2b_count: accepted %0d results %0d required 4 4", nacc, nres);
        end
        for (int i = 1; i < 4; i++) begin
            if (i < nacc) begin
                vectors++;
                if (acc[i] - acc[i-1] != 12) begin
                    miscompares++; $display("FAIL b2b_spacing_%0d: got %0d required 12", i, acc[i] - acc[i-1]);
                end
            end
        end
    endtask

    initial begin
        build_tables();
        test_reset();
        test_kat("kat_c1", C_P1, C_K1, C_C1);
        test_kat("kat_b", C_P2, C_K2, C_C2);
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
